// File: rtl/i2c_slave_regfile.sv
// I2C responder with a byte-wide register file behind a 7-bit bus address.
// SCL/SDA are oversampled on iClk. SDA is open-drain and SCL is never stretched.
module i2c_slave_regfile #(
  parameter logic [6:0]  SLV_ADDR = 7'h50,
  parameter int unsigned REG_NUM  = 16,
  localparam int unsigned PW      = $clog2(REG_NUM)
) (
  input  logic          iClk,
  input  logic          iRstn,
  input  logic          SCL,
  inout  wire           SDA,
  output logic          oWrStb,
  output logic [PW-1:0] oWrAddr,
  output logic [7:0]    oWrData,
  output logic          oBusy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StWaitStop
  } state_e;

  logic          scl_s1_q, scl_s2_q, scl_h_q;
  logic          sda_s1_q, sda_s2_q, sda_h_q;
  state_e        state_q;
  logic [7:0]    shift_q;
  logic [3:0]    cnt_q;
  logic [PW-1:0] ptr_q;
  logic          ptr_phase_q;
  logic          rw_q;
  logic          ack_on_q;
  logic          sda_oe_q;
  logic [7:0]    regs_q [REG_NUM];

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;

  // Open-drain: pull low or release, never drive high.
  assign SDA = sda_oe_q ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus one history stage for edge detection.
  // Idle bus level is high, so reset to 1 avoids spurious edges.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      {scl_s1_q, scl_s2_q, scl_h_q} <= 3'b111;
      {sda_s1_q, sda_s2_q, sda_h_q} <= 3'b111;
    end else begin
      scl_s1_q <= SCL;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= SDA;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign rx_byte   = {shift_q[6:0], sda_s2_q};
  assign rd_byte   = regs_q[ptr_q];

  // Protocol FSM, register file, pointer and all registered outputs.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      ptr_phase_q <= 1'b0;
      rw_q        <= 1'b0;
      ack_on_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      oWrStb      <= 1'b0;
      oWrAddr     <= '0;
      oWrData     <= '0;
      oBusy       <= 1'b0;
      for (int unsigned i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      oWrStb <= 1'b0;
      if (start_det) begin
        state_q  <= StAddr;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
        ack_on_q <= 1'b0;
        oBusy    <= 1'b1;
      end else if (stop_det) begin
        state_q  <= StIdle;
        sda_oe_q <= 1'b0;
        ack_on_q <= 1'b0;
        oBusy    <= 1'b0;
      end else begin
        case (state_q)
          StAddr: begin
            if (scl_rise) begin
              shift_q <= rx_byte;
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                cnt_q   <= '0;
                rw_q    <= rx_byte[0];
                state_q <= (rx_byte[7:1] == SLV_ADDR) ? StAddrAck : StWaitStop;
              end
            end
          end
          // First SCL fall starts the ACK, second ends it and hands over the bus.
          StAddrAck: begin
            if (scl_fall) begin
              if (!ack_on_q) begin
                sda_oe_q <= 1'b1;
                ack_on_q <= 1'b1;
              end else begin
                ack_on_q <= 1'b0;
                cnt_q    <= '0;
                if (rw_q) begin
                  // Read data MSB goes out on this same fall.
                  shift_q  <= {rd_byte[6:0], 1'b0};
                  sda_oe_q <= ~rd_byte[7];
                  state_q  <= StRdByte;
                end else begin
                  sda_oe_q    <= 1'b0;
                  ptr_phase_q <= 1'b1;
                  state_q     <= StWrByte;
                end
              end
            end
          end
          StWrByte: begin
            if (scl_rise) begin
              shift_q <= rx_byte;
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                cnt_q   <= '0;
                state_q <= StWrAck;
                if (ptr_phase_q) begin
                  ptr_q       <= rx_byte[PW-1:0];
                  ptr_phase_q <= 1'b0;
                end else begin
                  regs_q[ptr_q] <= rx_byte;
                  oWrStb        <= 1'b1;
                  oWrAddr       <= ptr_q;
                  oWrData       <= rx_byte;
                  ptr_q         <= ptr_q + PW'(1);
                end
              end
            end
          end
          StWrAck: begin
            if (scl_fall) begin
              if (!ack_on_q) begin
                sda_oe_q <= 1'b1;
                ack_on_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                ack_on_q <= 1'b0;
                state_q  <= StWrByte;
              end
            end
          end
          StRdByte: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                ptr_q    <= ptr_q + PW'(1);
                cnt_q    <= '0;
                state_q  <= StRdAck;
              end else begin
                sda_oe_q <= ~shift_q[7];
                shift_q  <= {shift_q[6:0], 1'b0};
              end
            end
          end
          StRdAck: begin
            if (scl_rise) begin
              if (!sda_s2_q) begin
                shift_q <= rd_byte;
                cnt_q   <= '0;
                state_q <= StRdByte;
              end else begin
                state_q <= StWaitStop;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: bit-banged I2C master plus a transaction-level model of the
// register file, pointer and expected write strobes.
module tb_i2c_slave_regfile;

  localparam int Q = 4;  // quarter of an SCL bit period, in iClk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  wire        sda;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_regfile #(
    .SLV_ADDR(7'h50),
    .REG_NUM (16)
  ) dut (
    .iClk   (clk),
    .iRstn  (rst_n),
    .SCL    (scl),
    .SDA    (sda),
    .oWrStb (wr_stb),
    .oWrAddr(wr_addr),
    .oWrData(wr_data),
    .oBusy  (busy)
  );

  // Transaction-level model
  typedef enum {PhIdle, PhAddr, PhPtr, PhData, PhRead, PhIgnore} ph_e;
  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] m_regs [16];
  int         m_ptr = 0;
  ph_e        m_ph = PhIdle;
  wr_t        exp_q[$];
  wr_t        e;
  logic [3:0] hold_a;
  logic [7:0] hold_d;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  // Strobe scoreboard and hold check on every cycle out of reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_a = '0;
      hold_d = '0;
    end else begin
      if (wr_stb === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: got addr %0d data %02h, want no strobe",
                   wr_addr, wr_data);
          hold_a = wr_addr;
          hold_d = wr_data;
        end else begin
          e = exp_q.pop_front();
          hold_a = e.a;
          hold_d = e.d;
        end
      end
      vectors++;
      if (wr_addr !== hold_a || wr_data !== hold_d) begin
        miscompares++;
        $display("FAIL wr_hold: got %0d/%02h want %0d/%02h", wr_addr, wr_data, hold_a, hold_d);
      end
    end
  end

  task automatic bit_xfer(input logic b, output logic r);
    repeat (Q) @(negedge clk);
    m_oe = ~b;
    repeat (Q) @(negedge clk);
    scl = 1'b1;
    repeat (Q) @(negedge clk);
    r = sda;
    repeat (Q) @(negedge clk);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      repeat (Q) @(negedge clk);
      m_oe = 1'b0;
      repeat (Q) @(negedge clk);
      scl = 1'b1;
    end
    repeat (Q) @(negedge clk);
    m_oe = 1'b1;
    repeat (Q) @(negedge clk);
    check8("busy_after_start", {7'd0, busy}, 8'd1);
    scl = 1'b0;
    m_ph = PhAddr;
  endtask

  task automatic i2c_stop();
    repeat (Q) @(negedge clk);
    m_oe = 1'b1;
    repeat (Q) @(negedge clk);
    scl = 1'b1;
    repeat (Q) @(negedge clk);
    m_oe = 1'b0;
    repeat (2 * Q) @(negedge clk);
    check8("busy_after_stop", {7'd0, busy}, 8'd0);
    m_ph = PhIdle;
  endtask

  task automatic wr_byte(input logic [7:0] b, input string name);
    logic exp_ack;
    logic r;
    exp_ack = 1'b0;
    case (m_ph)
      PhAddr: begin
        exp_ack = (b[7:1] == 7'h50);
        m_ph = exp_ack ? (b[0] ? PhRead : PhPtr) : PhIgnore;
      end
      PhPtr: begin
        exp_ack = 1'b1;
        m_ptr = int'(b) % 16;
        m_ph = PhData;
      end
      PhData: begin
        exp_ack = 1'b1;
        exp_q.push_back('{a: 4'(m_ptr), d: b});
        m_regs[m_ptr] = b;
        m_ptr = (m_ptr + 1) % 16;
      end
      default: exp_ack = 1'b0;
    endcase
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    check8({name, "_ack"}, {7'd0, r}, {7'd0, ~exp_ack});
    check8({name, "_strobes_pending"}, 8'(exp_q.size()), 8'd0);
  endtask

  task automatic rd_byte(input logic ack, input string name, output logic [7:0] got);
    logic [7:0] exp;
    logic r;
    exp = m_regs[m_ptr];
    m_ptr = (m_ptr + 1) % 16;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      got[i] = r;
    end
    bit_xfer(ack, r);
    check8(name, got, exp);
    if (ack) m_ph = PhIgnore;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    logic [7:0] a0;
    logic       r;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check8("rst_busy", {7'd0, busy}, 8'd0);
    check8("rst_stb", {7'd0, wr_stb}, 8'd0);
    check8("rst_sda", {7'd0, sda}, 8'd1);
    check8("rst_addr", {4'd0, wr_addr}, 8'd0);
    check8("rst_data", wr_data, 8'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write 0x55 to register 3
    i2c_start();
    wr_byte(8'hA0, "w1_addr");
    wr_byte(8'h03, "w1_ptr");
    wr_byte(8'h55, "w1_data");
    i2c_stop();

    // Read back through a repeated start
    i2c_start();
    wr_byte(8'hA0, "r1_waddr");
    wr_byte(8'h03, "r1_ptr");
    i2c_start();
    wr_byte(8'hA1, "r1_raddr");
    rd_byte(1'b0, "r1_byte0", got);
    check8("r1_byte0_literal", got, 8'h55);
    rd_byte(1'b1, "r1_byte1", got);
    check8("r1_byte1_literal", got, 8'h00);
    check8("r1_model_ptr", 8'(m_ptr), 8'd5);
    i2c_stop();

    // Pointer wrap
    i2c_start();
    wr_byte(8'hA0, "wrap_addr");
    wr_byte(8'h0F, "wrap_ptr");
    wr_byte(8'h11, "wrap_d0");
    wr_byte(8'h22, "wrap_d1");
    i2c_stop();
    i2c_start();
    wr_byte(8'hA0, "wrap_raddr_w");
    wr_byte(8'h0F, "wrap_rptr");
    i2c_start();
    wr_byte(8'hA1, "wrap_raddr_r");
    rd_byte(1'b0, "wrap_r0", got);
    check8("wrap_r0_literal", got, 8'h11);
    rd_byte(1'b1, "wrap_r1", got);
    check8("wrap_r1_literal", got, 8'h22);
    i2c_stop();

    // Address mismatch: NACK and ignore until STOP
    i2c_start();
    wr_byte(8'hA2, "mis_addr");
    wr_byte(8'h05, "mis_b0");
    wr_byte(8'h66, "mis_b1");
    i2c_stop();
    i2c_start();
    wr_byte(8'hA0, "post_mis_addr");
    wr_byte(8'h07, "post_mis_ptr");
    wr_byte(8'h3C, "post_mis_data");
    i2c_stop();

    // Pointer-only write, then read that register
    i2c_start();
    wr_byte(8'hA0, "po_addr");
    wr_byte(8'h07, "po_ptr");
    i2c_stop();
    i2c_start();
    wr_byte(8'hA1, "po_raddr");
    rd_byte(1'b1, "po_r0", got);
    check8("po_r0_literal", got, 8'h3C);
    i2c_stop();

    // Reset while the address ACK holds SDA low
    i2c_start();
    a0 = 8'hA0;
    for (int i = 7; i >= 0; i--) bit_xfer(a0[i], r);
    repeat (Q) @(negedge clk);
    m_oe = 1'b0;
    #1;
    check8("mid_ack_sda_low", {7'd0, sda}, 8'd0);
    rst_n = 1'b0;
    #1;
    check8("reset_sda_release", {7'd0, sda}, 8'd1);
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    m_ph = PhIdle;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (Q) @(negedge clk);
    scl = 1'b1;
    repeat (4 * Q) @(negedge clk);
    check8("post_reset_busy", {7'd0, busy}, 8'd0);

    // Every register must read back zero
    i2c_start();
    wr_byte(8'hA0, "dump_waddr");
    wr_byte(8'h00, "dump_ptr");
    i2c_start();
    wr_byte(8'hA1, "dump_raddr");
    for (int i = 0; i < 16; i++) begin
      rd_byte(i == 15, $sformatf("dump_r%0d", i), got);
      if (i == 3 || i == 15) check8($sformatf("dump_r%0d_literal", i), got, 8'h00);
    end
    i2c_stop();

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
